anc_lms_ctrl: RTL
=================

// Module: anc_lms_ctrl
// PURPOSE
//  Sample-rate controller directly upstream of the adaptive FIR. Pairs reference-mic (x) and error-mic (e) samples.
//  Computes the LMS weight-adjust term mu*e and launches one FIR run per sample pair.
//  Collects the FIR result and presents it to the DAC path with a one-cycle valid pulse.
//  Adds a watchdog on the FIR run, plus sticky overrun and timeout status.
// PARAMETERS
//  TIMEOUT    512   max cycles from fir_go to fir_done before abort (must exceed TAPS+7 of FIR)
//  DZ_THRESH  16    |e| deadzone threshold in LSBs (used only with ANC_ERR_DEADZONE_EN)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous, active-low reset
//  enable         in   1   allow new FIR runs to start
//  clr_status     in   1   synchronous clear of overrun/timeout_err
//  mu             in   16  signed Q1.15 step size, static during operation
//  dc_offset      in   16  signed, forwarded as FIR accumulator init (a_out)
//  ref_in         in   16  signed Q1.15 reference sample
//  ref_valid      in   1   ref_in strobe, 1 cycle
//  err_in         in   16  signed Q1.15 error sample
//  err_valid      in   1   err_in strobe, 1 cycle
//  fir_out        in   16  FIR result
//  fir_out_valid  in   1   FIR result strobe
//  fir_done       in   1   FIR completion strobe
//  fir_go         out  1   one-cycle FIR start
//  x_out          out  16  sample to FIR x_in
//  a_out          out  16  to FIR a_in
//  wadj_out       out  16  to FIR weight_adjust
//  dac_out        out  16  latest FIR result
//  dac_valid      out  1   one-cycle strobe with dac_out
//  busy           out  1   FSM not in IDLE
//  overrun        out  1   sticky: pending sample overwritten
//  timeout_err    out  1   sticky: FIR run aborted by watchdog
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pending flags 0, watchdog counter 0. The FIR shares rst_n.
//  Capture:
//   - ref_valid latches ref_in into ref_hold and sets ref_pend. err_valid does the same into err_hold/err_pend.
//   - Each latch is independent and accepted in any FSM state.
//   - A strobe while the matching pend is already set, and not consumed that cycle: overwrite hold, set overrun.
//   - A strobe on the consume cycle: the old value is consumed and the new value becomes pending. No overrun.
//  FSM: IDLE -> MUL -> GO -> WAIT -> IDLE.
//   - IDLE: if enable & ref_pend & err_pend -> MUL.
//       Consume both holds: clear both pends, copy ref_hold to x_out, copy dc_offset to a_out.
//   - MUL: prod = mu*err_hold (32b signed, registered).
//   - GO: wadj_out = sat16(prod >>> 15); the only saturating case is -1*-1 -> 0x7FFF. fir_go=1 for this cycle only.
//       x_out, a_out and wadj_out are held stable from GO until the next MUL.
//   - WAIT: watchdog counts from 1.
//       On fir_done: dac_out <= fir_out if fir_out_valid (else unchanged); dac_valid=1 next cycle; -> IDLE.
//       Watchdog == TIMEOUT without fir_done: set timeout_err, no dac_valid, -> IDLE.
//   - fir_done outside WAIT is ignored.
//  Latency: IDLE consume to fir_go = 2 cycles. fir_done to dac_valid = 1 cycle.
//  enable deasserted mid-run: the current run completes normally; no new run starts.
//  clr_status coincident with a set event: the set wins.
//  busy = (state != IDLE).
// CONFIGURATION
//  ANC_ERR_DEADZONE_EN defined: in GO, if |err_hold| < DZ_THRESH then wadj_out = 0, which freezes adaptation.
//   |-32768| is treated as 32768.
//  Not defined: wadj_out is always sat16(prod>>>15), and DZ_THRESH is unused.
// STRUCTURE
//  anc_pkg: Q1.15 width (16), product width (32), FSM state encoding, TIMEOUT counter width ($clog2(TIMEOUT+1)).
//  Reuse the existing saturate (33->16) for wadj_out. Reuse bw_mult for mu*err.
//  No new sub-module.
// TESTING
//  1. ref=0x4000, err=0x2000, mu=0x4000 -> fir_go 2 cyc after pairing, x_out=0x4000, wadj_out=0x1000.
//     Model FIR returns 0x1234 -> dac_out=0x1234 with a 1-cycle dac_valid.
//  2. mu=0x8000, err=0x8000 -> wadj_out=0x7FFF (saturated).
//     mu=0x8000, err=0x7FFF -> wadj_out=0x8001.
//  3. Two ref_valid strobes before any err_valid -> overrun=1, second ref used as x_out.
//     clr_status -> overrun=0.
//  4. FIR model never asserts done -> timeout_err=1 after 512 WAIT cycles, busy=0, no dac_valid.
//     The next pair starts normally.
//  5. With ANC_ERR_DEADZONE_EN: err=0x000F -> wadj_out=0. err=0xFFF0 (-16) -> wadj_out = nonzero product.
//  6. Assert rst_n low during WAIT -> all outputs 0 immediately, pends cleared.
//     enable=0 with both pends set -> no fir_go.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared types and helpers for the ANC LMS sample-rate controller.
// Optional feature macro: ANC_ERR_DEADZONE_EN (see anc_lms_ctrl.sv).
package anc_pkg;

    localparam int Q15_W         = 16;
    localparam int PROD_W        = 32;
    localparam int TIMEOUT_DEF   = 512;
    localparam int DZ_THRESH_DEF = 16;

    typedef logic signed [Q15_W-1:0]  q15_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_GO   = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic q15_t sat16(input logic signed [PROD_W:0] v);
        q15_t r;
        if (v > 33'sd32767) begin
            r = 16'sh7fff;
        end else if (v < -33'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[Q15_W-1:0];
        end
        return r;
    endfunction

    // 17 bits so that |-32768| is representable
    function automatic logic [Q15_W:0] abs17(input q15_t v);
        logic signed [Q15_W:0] w;
        w = {v[Q15_W-1], v};
        return w[Q15_W] ? 17'(-w) : 17'(w);
    endfunction

endpackage

// File: rtl/anc_lms_ctrl_if.sv
// Controller <-> environment bundle: mic samples, FIR handshake, DAC path, status.
// master = controller side, slave = mics/FIR/DAC side.
interface anc_lms_ctrl_if;

    logic           enable;
    logic           clr_status;
    anc_pkg::q15_t  mu;
    anc_pkg::q15_t  dc_offset;
    anc_pkg::q15_t  ref_in;
    logic           ref_valid;
    anc_pkg::q15_t  err_in;
    logic           err_valid;
    anc_pkg::q15_t  fir_out;
    logic           fir_out_valid;
    logic           fir_done;
    logic           fir_go;
    anc_pkg::q15_t  x_out;
    anc_pkg::q15_t  a_out;
    anc_pkg::q15_t  wadj_out;
    anc_pkg::q15_t  dac_out;
    logic           dac_valid;
    logic           busy;
    logic           overrun;
    logic           timeout_err;

    modport master (
        input  enable, clr_status, mu, dc_offset,
        input  ref_in, ref_valid, err_in, err_valid,
        input  fir_out, fir_out_valid, fir_done,
        output fir_go, x_out, a_out, wadj_out,
        output dac_out, dac_valid, busy, overrun, timeout_err
    );

    modport slave (
        output enable, clr_status, mu, dc_offset,
        output ref_in, ref_valid, err_in, err_valid,
        output fir_out, fir_out_valid, fir_done,
        input  fir_go, x_out, a_out, wadj_out,
        input  dac_out, dac_valid, busy, overrun, timeout_err
    );

endinterface

// File: rtl/anc_lms_ctrl.sv
// ANC LMS controller: pairs x/e samples, forms mu*e, runs the FIR, forwards result to DAC.
// Define ANC_ERR_DEADZONE_EN to zero the weight adjust while |e| < DZ_THRESH.
module anc_lms_ctrl
    import anc_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int DZ_THRESH = DZ_THRESH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    anc_lms_ctrl_if.master  bus
);

    localparam int WD_W = wd_width(TIMEOUT);

    state_e          state_q;
    q15_t            ref_hold_q;
    q15_t            err_hold_q;
    q15_t            err_use_q;
    logic            ref_pend_q;
    logic            err_pend_q;
    logic [WD_W-1:0] wdog_q;

    logic fir_go_q;
    q15_t x_q;
    q15_t a_q;
    q15_t wadj_q;
    q15_t dac_q;
    logic dac_valid_q;
    logic ovr_q;
    logic to_q;

    logic                   consume;
    prod_t                  prod;
    logic signed [PROD_W:0] prod_sh;
    q15_t                   wadj_d;

    assign consume = (state_q == S_IDLE) & bus.enable
                   & ref_pend_q & err_pend_q;

    assign prod    = bus.mu * err_use_q;
    assign prod_sh = $signed({prod[PROD_W-1], prod}) >>> 15;

`ifdef ANC_ERR_DEADZONE_EN
    assign wadj_d = (abs17(err_use_q) < 17'(DZ_THRESH))
                  ? '0 : sat16(prod_sh);
`else
    assign wadj_d = sat16(prod_sh);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ref_hold_q  <= '0;
            err_hold_q  <= '0;
            err_use_q   <= '0;
            ref_pend_q  <= 1'b0;
            err_pend_q  <= 1'b0;
            wdog_q      <= '0;
            fir_go_q    <= 1'b0;
            x_q         <= '0;
            a_q         <= '0;
            wadj_q      <= '0;
            dac_q       <= '0;
            dac_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            fir_go_q    <= 1'b0;
            dac_valid_q <= 1'b0;

            // later set events override this clear
            if (bus.clr_status) begin
                ovr_q <= 1'b0;
                to_q  <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (consume) begin
                        state_q   <= S_MUL;
                        x_q       <= ref_hold_q;
                        a_q       <= bus.dc_offset;
                        err_use_q <= err_hold_q;
                    end
                end
                S_MUL: begin
                    state_q  <= S_GO;
                    wadj_q   <= wadj_d;
                    fir_go_q <= 1'b1;
                end
                S_GO: begin
                    state_q <= S_WAIT;
                    wdog_q  <= WD_W'(1);
                end
                S_WAIT: begin
                    if (bus.fir_done) begin
                        if (bus.fir_out_valid) begin
                            dac_q <= bus.fir_out;
                        end
                        dac_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                        wdog_q      <= '0;
                    end else if (wdog_q == WD_W'(TIMEOUT)) begin
                        to_q    <= 1'b1;
                        state_q <= S_IDLE;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // a strobe on the consume cycle refills the hold without overrun
            if (bus.ref_valid) begin
                ref_hold_q <= bus.ref_in;
                ref_pend_q <= 1'b1;
                if (ref_pend_q && !consume) begin
                    ovr_q <= 1'b1;
                end
            end else if (consume) begin
                ref_pend_q <= 1'b0;
            end

            if (bus.err_valid) begin
                err_hold_q <= bus.err_in;
                err_pend_q <= 1'b1;
                if (err_pend_q && !consume) begin
                    ovr_q <= 1'b1;
                end
            end else if (consume) begin
                err_pend_q <= 1'b0;
            end
        end
    end

    assign bus.fir_go      = fir_go_q;
    assign bus.x_out       = x_q;
    assign bus.a_out       = a_q;
    assign bus.wadj_out    = wadj_q;
    assign bus.dac_out     = dac_q;
    assign bus.dac_valid   = dac_valid_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.overrun     = ovr_q;
    assign bus.timeout_err = to_q;

endmodule
